// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D-cache memory arbiter with round-robin tie-break and a fixed-latency read-return pipeline.
module mem_arbiter #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_rd,
    input  logic [15:0] i_addr,
    input  logic        d_req_rd,
    input  logic        d_req_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic [15:0] m_data_out,
    input  logic        m_stall,
    input  logic        m_err,
    input  logic [3:0]  m_busy,
    output logic [15:0] fm_addr,
    output logic [15:0] fm_data_in,
    output logic        fm_rd,
    output logic        fm_wr,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic        i_valid,
    output logic        d_valid,
    output logic [15:0] i_data_out,
    output logic [15:0] d_data_out,
    output logic        err
);
    logic                d_illegal, i_elig, d_elig, gnt_i, gnt_d, push_vld;
    logic                last_d_q, last_d_d, err_q, err_d;
    logic [READ_LAT-1:0] vld_q, vld_d, own_q, own_d;

    always_comb begin
        d_illegal = d_req_rd & d_req_wr;
        i_elig    = rst & ~m_stall & i_req_rd & ~m_busy[i_addr[2:1]];
        d_elig    = rst & ~m_stall & (d_req_rd ^ d_req_wr) & ~m_busy[d_addr[2:1]];
        // last_d_q=1 means D won most recently, so a tie goes to I
        gnt_i     = i_elig & (~d_elig | last_d_q);
        gnt_d     = d_elig & (~i_elig | ~last_d_q);
        push_vld  = gnt_i | (gnt_d & d_req_rd);
        last_d_d  = gnt_d | (~gnt_i & last_d_q);
        err_d     = err_q | m_err | d_illegal;
        vld_d     = '0;
        own_d     = '0;
        vld_d[0]  = push_vld;
        own_d[0]  = gnt_d;
        for (int k = 1; k < READ_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            own_d[k] = own_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q    <= '0;
            own_q    <= '0;
            last_d_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            own_q    <= own_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        i_gnt      = gnt_i;
        d_gnt      = gnt_d;
        fm_rd      = push_vld;
        fm_wr      = gnt_d & d_req_wr;
        fm_addr    = gnt_i ? i_addr : (gnt_d ? d_addr : 16'h0);
        fm_data_in = gnt_d ? d_data_in : 16'h0;
        i_valid    = rst & vld_q[READ_LAT-1] & ~own_q[READ_LAT-1];
        d_valid    = rst & vld_q[READ_LAT-1] & own_q[READ_LAT-1];
        i_data_out = i_valid ? m_data_out : 16'h0;
        d_data_out = d_valid ? m_data_out : 16'h0;
        err        = rst & err_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tasks with inline checks against hand-computed values.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_rd, d_req_rd, d_req_wr, m_stall, m_err;
    logic [15:0] i_addr, d_addr, d_data_in, m_data_out;
    logic [3:0]  m_busy;
    logic [15:0] fm_addr, fm_data_in, i_data_out, d_data_out;
    logic        fm_rd, fm_wr, i_gnt, d_gnt, i_valid, d_valid, err;
    int          checks = 0;
    int          errors = 0;

    mem_arbiter #(.READ_LAT(2)) dut (
        .clk(clk), .rst(rst), .i_req_rd(i_req_rd), .i_addr(i_addr),
        .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .m_data_out(m_data_out), .m_stall(m_stall), .m_err(m_err), .m_busy(m_busy),
        .fm_addr(fm_addr), .fm_data_in(fm_data_in), .fm_rd(fm_rd), .fm_wr(fm_wr),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .i_valid(i_valid), .d_valid(d_valid),
        .i_data_out(i_data_out), .d_data_out(d_data_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req_rd = 0; d_req_rd = 0; d_req_wr = 0; m_stall = 0; m_err = 0;
        i_addr = 0; d_addr = 0; d_data_in = 0; m_data_out = 0; m_busy = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 0; i_req_rd = 1; i_addr = 16'h0010; d_req_wr = 1; d_addr = 16'h0002;
        d_data_in = 16'h0055; m_err = 1; m_data_out = 16'hFFFF;
        #2;
        checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL rst_i_gnt: got %0b expected 0", i_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt: got %0b expected 0", d_gnt); end
        checks++; if ({fm_rd, fm_wr} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {fm_rd, fm_wr}); end
        checks++; if (fm_addr !== 16'h0) begin errors++; $display("FAIL rst_fm_addr: got %h expected 0000", fm_addr); end
        checks++; if (fm_data_in !== 16'h0) begin errors++; $display("FAIL rst_fm_data_in: got %h expected 0000", fm_data_in); end
        checks++; if ({i_valid, d_valid, err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {i_valid, d_valid, err}); end
        step();
        idle();
        rst = 1;
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err_after: got %0b expected 0", err); end
        step();
    endtask

    task automatic test_basic_read();
        i_req_rd = 1; i_addr = 16'h0010;
        #2;
        checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rd_i_gnt: got %0b expected 1", i_gnt); end
        checks++; if ({fm_rd, fm_wr} !== 2'b10) begin errors++; $display("FAIL rd_strobes: got %b expected 10", {fm_rd, fm_wr}); end
        checks++; if (fm_addr !== 16'h0010) begin errors++; $display("FAIL rd_fm_addr: got %h expected 0010", fm_addr); end
        step();
        idle(); m_data_out = 16'h1111;
        #2;
        checks++; if ({i_valid, i_data_out} !== 17'h0) begin errors++; $display("FAIL rd_early_valid: got %b/%h expected 0/0000", i_valid, i_data_out); end
        step();
        m_data_out = 16'hBEEF;
        #2;
        checks++; if (i_valid !== 1'b1) begin errors++; $display("FAIL rd_i_valid: got %0b expected 1", i_valid); end
        checks++; if (i_data_out !== 16'hBEEF) begin errors++; $display("FAIL rd_i_data: got %h expected beef", i_data_out); end
        checks++; if ({d_valid, d_data_out} !== 17'h0) begin errors++; $display("FAIL rd_d_quiet: got %b/%h expected 0/0000", d_valid, d_data_out); end
        step();
        #2;
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL rd_i_valid_once: got %0b expected 0", i_valid); end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        i_req_rd = 1; i_addr = 16'h0000; d_req_wr = 1; d_addr = 16'h0002; d_data_in = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            #2;
            checks++; if ({i_gnt, d_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, {i_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            checks++; if (fm_wr !== (k % 2 == 1)) begin errors++; $display("FAIL rr_fm_wr[%0d]: got %0b expected %0b", k, fm_wr, k % 2); end
            checks++; if (fm_addr !== ((k % 2 == 0) ? 16'h0000 : 16'h0002)) begin errors++; $display("FAIL rr_fm_addr[%0d]: got %h", k, fm_addr); end
            checks++; if (fm_data_in !== ((k % 2 == 0) ? 16'h0000 : 16'h1234)) begin errors++; $display("FAIL rr_fm_data_in[%0d]: got %h", k, fm_data_in); end
            step();
        end
        idle();
        repeat (3) step();
    endtask

    task automatic test_no_hol();
        i_req_rd = 1; i_addr = 16'h0004; m_busy = 4'b0100; d_req_rd = 1; d_addr = 16'h0006;
        #2;
        checks++; if ({i_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL hol_gnt: got %b expected 01", {i_gnt, d_gnt}); end
        checks++; if ({fm_rd, fm_addr} !== {1'b1, 16'h0006}) begin errors++; $display("FAIL hol_fm: got %b/%h expected 1/0006", fm_rd, fm_addr); end
        step();
        d_req_rd = 0; d_addr = 0; m_busy = 0;
        #2;
        checks++; if ({i_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL hol_i_after: got %b expected 10", {i_gnt, d_gnt}); end
        checks++; if (fm_addr !== 16'h0004) begin errors++; $display("FAIL hol_i_addr: got %h expected 0004", fm_addr); end
        step();
        i_addr = 16'h0008; m_stall = 1;
        #2;
        checks++; if ({i_gnt, fm_rd, fm_addr} !== 18'h0) begin errors++; $display("FAIL stall_block: got %b/%b/%h expected 0/0/0000", i_gnt, fm_rd, fm_addr); end
        step();
        m_stall = 0;
        #2;
        checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL stall_release: got %0b expected 1", i_gnt); end
        step();
        idle();
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic [5:0] iv, dv;
        logic [15:0] md;
        iv = 6'b010100;
        dv = 6'b001000;
        for (int c = 0; c < 6; c++) begin
            idle();
            md = 16'hA000 + 16'(c);
            m_data_out = md;
            if (c == 0) begin i_req_rd = 1; i_addr = 16'h0010; end
            if (c == 1) begin d_req_rd = 1; d_addr = 16'h0020; end
            if (c == 2) begin i_req_rd = 1; i_addr = 16'h0030; end
            #2;
            checks++; if ({i_gnt, d_gnt} !== {c == 0 || c == 2, c == 1}) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b", c, {i_gnt, d_gnt}); end
            checks++; if ({i_valid, d_valid} !== {iv[c], dv[c]}) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, {i_valid, d_valid}, {iv[c], dv[c]}); end
            checks++; if (i_data_out !== (iv[c] ? md : 16'h0)) begin errors++; $display("FAIL b2b_i_data[%0d]: got %h", c, i_data_out); end
            checks++; if (d_data_out !== (dv[c] ? md : 16'h0)) begin errors++; $display("FAIL b2b_d_data[%0d]: got %h", c, d_data_out); end
            step();
        end
    endtask

    task automatic test_reset_inflight();
        idle(); i_req_rd = 1; i_addr = 16'h0010;
        #2;
        checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rif_i_gnt: got %0b expected 1", i_gnt); end
        step();
        idle(); d_req_rd = 1; d_addr = 16'h0020;
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rif_d_gnt: got %0b expected 1", d_gnt); end
        step();
        idle(); rst = 0; i_req_rd = 1; i_addr = 16'h0040; m_data_out = 16'h7777;
        #2;
        checks++; if ({i_valid, d_valid, i_data_out, d_data_out} !== 34'h0) begin errors++; $display("FAIL rif_during: got %b%b/%h/%h expected all 0", i_valid, d_valid, i_data_out, d_data_out); end
        checks++; if ({i_gnt, d_gnt, fm_rd, fm_wr, fm_addr} !== 20'h0) begin errors++; $display("FAIL rif_during_gnt: got %b/%h expected 0/0000", {i_gnt, d_gnt, fm_rd, fm_wr}, fm_addr); end
        step();
        for (int c = 0; c < 2; c++) begin
            idle(); rst = 1; m_data_out = 16'h8888;
            #2;
            checks++; if ({i_valid, d_valid, i_data_out, d_data_out} !== 34'h0) begin errors++; $display("FAIL rif_after[%0d]: got %b%b/%h/%h expected all 0", c, i_valid, d_valid, i_data_out, d_data_out); end
            step();
        end
    endtask

    task automatic test_error();
        idle(); i_req_rd = 1; i_addr = 16'h0010; d_req_rd = 1; d_req_wr = 1; d_addr = 16'h0002;
        #2;
        checks++; if ({i_gnt, d_gnt, fm_wr} !== 3'b100) begin errors++; $display("FAIL ill_gnt: got %b expected 100", {i_gnt, d_gnt, fm_wr}); end
        checks++; if (fm_addr !== 16'h0010) begin errors++; $display("FAIL ill_fm_addr: got %h expected 0010", fm_addr); end
        step();
        idle();
        #2;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err: got %0b expected 1", err); end
        step();
        do_reset();
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b expected 0", err); end
        m_err = 1;
        step();
        m_err = 0;
        #2;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL merr_set: got %0b expected 1", err); end
        step(); step();
        #2;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL merr_sticky: got %0b expected 1", err); end
        rst = 0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL merr_in_rst: got %0b expected 0", err); end
        step();
        rst = 1;
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL merr_post_rst: got %0b expected 0", err); end
        step();
    endtask

    initial begin
        idle();
        rst = 0;
        step();
        test_reset();
        test_basic_read();
        test_round_robin();
        test_no_hol();
        test_back_to_back();
        test_reset_inflight();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
